inst_fetch: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of decode and immediate generation. Holds the program counter, issues word requests to instruction memory over a valid/ready request channel, and buffers returned words in a small in-order queue. Presents each word to decode as `inst_code` with its `inst_pc` over a valid/ready handshake. Handles control-flow redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/inst_fetch.sv | 174 +++++++++++++++++
 tb/tb_inst_fetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I instruction fetch stage.
// Holds the PC, issues word requests over a valid/ready channel under a
// credit limit, and buffers returned words with their PCs in an in-order
// queue toward decode. Redirects flush the queue and drop stale responses.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target
// sets a sticky misalign_err and halts fetch until reset. Without it, the
// redirect target is forced to a word boundary.
module inst_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_code,
   output logic [31:0] inst_pc,
   output logic        misalign_err
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   // Dropped responses can accumulate across back-to-back redirects while
   // new requests keep issuing, so the drop counter is kept generously wide.
   localparam int DW = 16;

   typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] drop_q, drop_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

   logic [31:0]   code_mem [BUF_DEPTH];
   logic [31:0]   pc_mem   [BUF_DEPTH];
   logic [31:0]   tag_mem  [BUF_DEPTH];

   logic [31:0]   tgt_pc;
   logic          misalign_hit;
   logic          acc, pop, push, tag_wr_en;
   logic [CW:0]   credit_used;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   assign tgt_pc       = redirect_pc;
   assign misalign_hit = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign misalign_err = misalign_q;

   // Sticky misaligned-target flag, cleared only by reset.
   always_comb begin
      misalign_d = misalign_q | misalign_hit;
   end

   // Misalign flag register.
   always_ff @(posedge clk) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end
`else
   logic unused_pc_lsbs;

   assign tgt_pc         = {redirect_pc[31:2], 2'b00};
   assign misalign_hit   = 1'b0;
   assign unused_pc_lsbs = ^redirect_pc[1:0];
   assign misalign_err   = 1'b0;
`endif

   // Request side and queue head: driven only from registers (plus reset),
   // so neither ready input feeds imem_req_valid.
   always_comb begin
      credit_used    = {1'b0, out_q} + {1'b0, cnt_q};
      imem_req_valid = (state_q == S_FETCH) && !reset &&
                       (credit_used < (CW+1)'(BUF_DEPTH));
      imem_req_addr  = pc_q;
      inst_valid     = (cnt_q != '0);
      inst_code      = inst_valid ? code_mem[rd_ptr_q] : 32'h0;
      inst_pc        = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;
   end

   // Next-state: PC, credit/drop accounting, queue pointers; redirect wins.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      out_d     = out_q;
      cnt_d     = cnt_q;
      drop_d    = drop_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      tag_rd_d  = tag_rd_q;
      tag_wr_d  = tag_wr_q;
      push      = 1'b0;
      tag_wr_en = 1'b0;
      acc       = imem_req_valid && imem_req_ready;
      pop       = inst_valid && inst_ready;

      if (redirect_valid) begin
         // Every in-flight response (outstanding, plus one accepted now)
         // becomes a drop; a response arriving this cycle is discarded here.
         pc_d     = tgt_pc;
         out_d    = '0;
         cnt_d    = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         tag_rd_d = '0;
         tag_wr_d = '0;
         drop_d   = drop_q + DW'(out_q) + DW'(acc) - DW'(imem_rsp_valid);
         if (misalign_hit) state_d = S_HALT;
      end else begin
         if (acc) begin
            pc_d      = pc_q + 32'd4;
            tag_wr_en = 1'b1;
            tag_wr_d  = tag_wr_q + PW'(1);
         end
         if (imem_rsp_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - DW'(1);
            end else begin
               push     = 1'b1;
               wr_ptr_d = wr_ptr_q + PW'(1);
               tag_rd_d = tag_rd_q + PW'(1);
            end
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         out_d = out_q + CW'(acc) - CW'(push);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         out_q    <= '0;
         cnt_q    <= '0;
         drop_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         tag_rd_q <= '0;
         tag_wr_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         out_q    <= out_d;
         cnt_q    <= cnt_d;
         drop_q   <= drop_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         tag_rd_q <= tag_rd_d;
         tag_wr_q <= tag_wr_d;
      end
   end

   // Queue and PC-tag storage; data only, validity tracked by the counters.
   always_ff @(posedge clk) begin
      if (push) begin
         code_mem[wr_ptr_q] <= imem_rsp_data;
         pc_mem[wr_ptr_q]   <= tag_mem[tag_rd_q];
      end
      if (tag_wr_en) tag_mem[tag_wr_q] <= pc_q;
   end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with an in-order memory model
// and a scoreboard of expected instruction PCs checked by a separate monitor.
module tb_inst_fetch;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_code;
   logic [31:0] inst_pc;
   logic        misalign_err;

   inst_fetch #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_code(inst_code), .inst_pc(inst_pc),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          delivered = 0;
   int          accepts = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mq[$];
   logic [31:0] exp_req;
   logic        rsp_en;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0001) ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef FETCH_MISALIGN_TRAP_EN
      return p;
`else
      return {p[31:2], 2'b00};
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_seg(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   // Wait for a cycle with both a request offered and a response returning.
   task automatic wait_busy();
      int n;
      n = 0;
      while (!(imem_req_valid && imem_rsp_valid) && n < 30) begin
         cyc(1);
         n++;
      end
      n_cmp++;
      if (n >= 30) begin
         n_fail++;
         $display("FAIL wait_busy: got no req+rsp cycle in %0d cycles, want one", n);
      end
   endtask

   // Single-cycle redirect with decode not accepting in that cycle.
   task automatic do_redirect(input logic [31:0] t, input logic [31:0] seg, input bit push);
      inst_ready     = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = t;
      exp_q.delete();
      if (push) push_seg(seg, 64);
      cyc(1);
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      chk("redir_inst_valid_next", 32'(inst_valid), 32'd0);
      inst_ready     = 1'b1;
   endtask

   // Memory model: in-order, responds one cycle after acceptance when enabled;
   // also checks every accepted request address against the expected PC.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      exp_req        = RPC;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
         end else if (rsp_en && mq.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
         end
         @(negedge clk);
         if (reset) begin
            exp_req = RPC;
         end else begin
            if (imem_req_valid && imem_req_ready) begin
               chk("req_addr", imem_req_addr, exp_req);
               exp_req = exp_req + 32'd4;
               mq.push_back(imem_req_addr);
               accepts++;
            end
            if (redirect_valid) exp_req = tgt(redirect_pc);
         end
      end
   end

   // Monitor: pops the scoreboard on every decode handshake.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!reset && inst_valid && inst_ready) begin
            delivered++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_inst: got pc %h, want no instruction", inst_pc);
            end else begin
               e = exp_q.pop_front();
               chk("inst_pc", inst_pc, e);
               chk("inst_code", inst_code, mem_word(e));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish by 100000, want finish");
      $fatal(1);
   end

   initial begin
      int d0;
      int a0;
      int a1;
      reset          = 1'b1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      rsp_en         = 1'b1;
      cyc(3);

      // Reset state.
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, RPC);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_code", inst_code, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_misalign", 32'(misalign_err), 32'd0);

      // First request right after reset; response-to-inst latency of one.
      push_seg(RPC, 64);
      reset = 1'b0;
      #1;
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, RPC);
      cyc(1);
      chk("lat_inst_valid_rsp_cycle", 32'(inst_valid), 32'd0);
      cyc(1);
      chk("lat_inst_valid_after", 32'(inst_valid), 32'd1);
      chk("lat_inst_pc", inst_pc, RPC);

      // Streaming with ready memory and decode.
      d0 = delivered;
      cyc(15);
      chk("stream_rate", 32'(delivered - d0 >= 9), 32'd1);

      // Decode stall: credit limit caps requests at the queue depth.
      inst_ready = 1'b0;
      a0 = accepts;
      cyc(10);
      chk("stall_accepts_le_depth", 32'(accepts - a0 <= 2), 32'd1);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_inst_valid", 32'(inst_valid), 32'd1);
      chk("stall_mem_empty", 32'(mq.size()), 32'd0);
      a1 = accepts;
      cyc(3);
      chk("stall_no_more_req", 32'(accepts), 32'(a1));
      inst_ready = 1'b1;
      cyc(3);
      chk("stall_release_req", 32'(accepts > a1), 32'd1);

      // Two requests in flight, then redirect: stale words must be dropped.
      rsp_en = 1'b0;
      cyc(8);
      chk("inflight_two", 32'(mq.size()), 32'd2);
      chk("inflight_req_valid", 32'(imem_req_valid), 32'd0);
      chk("inflight_drained", 32'(inst_valid), 32'd0);
      do_redirect(32'h0000_0200, 32'h0000_0200, 1'b1);
      chk("redir1_req_valid", 32'(imem_req_valid), 32'd1);
      chk("redir1_req_addr", imem_req_addr, 32'h0000_0200);
      rsp_en = 1'b1;
      d0 = delivered;
      cyc(12);
      chk("redir1_progress", 32'(delivered - d0 >= 4), 32'd1);

      // Redirect coinciding with a response and a request acceptance.
      wait_busy();
      do_redirect(32'h0000_0300, 32'h0000_0300, 1'b1);
      chk("redir2_req_valid", 32'(imem_req_valid), 32'd1);
      chk("redir2_req_addr", imem_req_addr, 32'h0000_0300);
      d0 = delivered;
      cyc(12);
      chk("redir2_progress", 32'(delivered - d0 >= 4), 32'd1);

      // PC wrap past 0xFFFF_FFFC.
      wait_busy();
      do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1);
      chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
      d0 = delivered;
      cyc(12);
      chk("wrap_progress", 32'(delivered - d0 >= 4), 32'd1);

      // Misaligned redirect target.
      wait_busy();
`ifdef FETCH_MISALIGN_TRAP_EN
      do_redirect(32'h0000_0202, 32'h0, 1'b0);
      chk("trap_misalign_set", 32'(misalign_err), 32'd1);
      chk("trap_req_valid", 32'(imem_req_valid), 32'd0);
      cyc(10);
      chk("trap_misalign_sticky", 32'(misalign_err), 32'd1);
      chk("trap_req_valid_held", 32'(imem_req_valid), 32'd0);
      chk("trap_inst_valid_held", 32'(inst_valid), 32'd0);
`else
      do_redirect(32'h0000_0202, 32'h0000_0200, 1'b1);
      chk("noalign_misalign", 32'(misalign_err), 32'd0);
      chk("noalign_req_addr", imem_req_addr, 32'h0000_0200);
      d0 = delivered;
      cyc(12);
      chk("noalign_progress", 32'(delivered - d0 >= 4), 32'd1);
`endif

      // Reset recovery.
      reset = 1'b1;
      cyc(2);
      chk("rerst_misalign", 32'(misalign_err), 32'd0);
      chk("rerst_inst_valid", 32'(inst_valid), 32'd0);
      exp_q.delete();
      push_seg(RPC, 64);
      reset = 1'b0;
      d0 = delivered;
      cyc(12);
      chk("rerst_progress", 32'(delivered - d0 >= 4), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
